// File: rtl/io_timer_pkg.sv
// Shared widths, register offsets, CTRL layout and state encoding for io_timer.
package io_timer_pkg;

  localparam int unsigned ARCH_WIDTH = 32;
  localparam int unsigned DMBE_WIDTH = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned CTRL_W     = 4;

  // Register offsets decoded from addr[28:29]
  localparam logic [SEL_W-1:0] TMR_CTRL_OFS   = 2'd0;
  localparam logic [SEL_W-1:0] TMR_PRESET_OFS = 2'd1;
  localparam logic [SEL_W-1:0] TMR_COUNT_OFS  = 2'd2;
  localparam logic [SEL_W-1:0] TMR_STATUS_OFS = 2'd3;

  // CTRL value-bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TMR_IDLE  = 2'd0,
    TMR_LOAD  = 2'd1,
    TMR_COUNT = 2'd2,
    TMR_INT   = 2'd3
  } tmr_state_e;

  // Packed in value-bit order: im = bit3, mode = bits2:1, en = bit0
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tmr_ctrl_t;

endpackage

// File: rtl/io_timer.sv
// Programmable down-counting IO timer: one-shot or auto-reload period counter
// with a maskable, sticky interrupt. Ports use big-endian bit numbering.
module io_timer
  import io_timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:ARCH_WIDTH-1] addr,
  input  logic                  wr,
  input  logic [0:DMBE_WIDTH-1] BE,
  input  logic [0:ARCH_WIDTH-1] din,
  output logic [0:ARCH_WIDTH-1] dout,
  output logic                  irq
);

  localparam logic [ARCH_WIDTH-1:0] ONE = ARCH_WIDTH'(1);

  // Byte-lane merge: BE[0] covers the most significant value byte
  function automatic logic [ARCH_WIDTH-1:0] be_merge(
    input logic [ARCH_WIDTH-1:0] old_val,
    input logic [ARCH_WIDTH-1:0] new_val,
    input logic [0:DMBE_WIDTH-1] be
  );
    logic [ARCH_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < ARCH_WIDTH; b++) begin
      if (be[DMBE_WIDTH-1-(b/BYTE_W)]) res[b] = new_val[b];
    end
    return res;
  endfunction

  tmr_state_e            state, state_nxt;
  tmr_ctrl_t             ctrl, ctrl_sw;
  logic [ARCH_WIDTH-1:0] preset, count, wdata, rd_val;
  logic                  pending;
  logic [SEL_W-1:0]      sel;
  logic                  wr_ctrl, wr_preset, clr_pend, en_eff, cnt_last;
  logic                  load_cnt, dec_cnt, zero_cnt, set_pend, hw_clr_en;
  logic                  unused_addr;

  // Vector assignment re-maps big-endian ports onto LSB-0 value bits
  assign wdata       = din;
  assign sel         = addr[28:29];
  assign unused_addr = ^{addr[0:27], addr[30:31]};

  assign wr_ctrl   = wr && (sel == TMR_CTRL_OFS);
  assign wr_preset = wr && (sel == TMR_PRESET_OFS);
  assign clr_pend  = wr && (sel == TMR_STATUS_OFS) && BE[DMBE_WIDTH-1] && wdata[0];
  assign ctrl_sw   = tmr_ctrl_t'(CTRL_W'(be_merge({{(ARCH_WIDTH-CTRL_W){1'b0}}, ctrl},
                                                  wdata, BE)));

  // A CTRL write takes effect on the same edge it is captured
  assign en_eff   = wr_ctrl ? ctrl_sw.en : ctrl.en;
  assign cnt_last = (count <= ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TMR_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_eff) begin
      state_nxt = TMR_IDLE;
    end else begin
      unique case (state)
        TMR_IDLE:  state_nxt = TMR_LOAD;
        TMR_LOAD:  state_nxt = TMR_COUNT;
        TMR_COUNT: if (cnt_last) state_nxt = TMR_INT;
        TMR_INT:   state_nxt = (ctrl.mode == MODE_RELOAD) ? TMR_LOAD : TMR_IDLE;
        default:   state_nxt = TMR_IDLE;
      endcase
    end
  end

  // Datapath controls; with EN low everything holds
  always_comb begin
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
    zero_cnt  = 1'b0;
    set_pend  = 1'b0;
    hw_clr_en = 1'b0;
    if (en_eff) begin
      unique case (state)
        TMR_LOAD:  load_cnt = 1'b1;
        TMR_COUNT: begin
          if (cnt_last) begin
            zero_cnt = 1'b1;
            set_pend = 1'b1;
          end else begin
            dec_cnt = 1'b1;
          end
        end
        TMR_INT:   hw_clr_en = (ctrl.mode != MODE_RELOAD);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl)        ctrl    <= ctrl_sw;
      else if (hw_clr_en) ctrl.en <= 1'b0;

      if (wr_preset) preset <= be_merge(preset, wdata, BE);

      if (load_cnt)      count <= (preset == '0) ? ONE : preset;
      else if (dec_cnt)  count <= count - ONE;
      else if (zero_cnt) count <= '0;

      if (set_pend)      pending <= 1'b1;
      else if (clr_pend) pending <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (sel)
      TMR_CTRL_OFS:   rd_val = {{(ARCH_WIDTH-CTRL_W){1'b0}}, ctrl};
      TMR_PRESET_OFS: rd_val = preset;
      TMR_COUNT_OFS:  rd_val = count;
      TMR_STATUS_OFS: rd_val = {{(ARCH_WIDTH-1){1'b0}}, pending};
      default:        rd_val = '0;
    endcase
  end

  assign dout = rd_val;
  assign irq  = pending & ctrl.im;

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer with hand-computed expected values.
module tb_io_timer;
  import io_timer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [0:31] addr;
  logic        wr;
  logic [0:3]  BE;
  logic [0:31] din;
  logic [0:31] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;

  io_timer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .wr   (wr),
    .BE   (BE),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write captured on the next rising edge; returns 1ns after that edge
  task automatic wr_reg(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    addr = {28'b0, sel, 2'b00};
    din  = data;
    BE   = be;
    wr   = 1'b1;
    @(posedge clk);
    #1;
    wr   = 1'b0;
    BE   = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    logic [31:0] v;
    addr = {28'b0, sel, 2'b00};
    #1;
    v = dout;
    chk(tag, v, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    BE    = 4'h0;
    din   = '0;
    addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    rd_chk("rst_ctrl",   TMR_CTRL_OFS,   32'h0);
    rd_chk("rst_preset", TMR_PRESET_OFS, 32'h0);
    rd_chk("rst_count",  TMR_COUNT_OFS,  32'h0);
    rd_chk("rst_status", TMR_STATUS_OFS, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot, N=5, IM=1
    wr_reg(TMR_PRESET_OFS, 32'd5, 4'hF);
    wr_reg(TMR_CTRL_OFS, 32'h9, 4'hF);
    rd_chk("os_count_load_edge", TMR_COUNT_OFS, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd_chk($sformatf("os_count_%0d", k), TMR_COUNT_OFS, 32'(6 - k) - ((k == 6) ? 32'd0 : 32'd0));
      chk($sformatf("os_irq_%0d", k), 32'(irq), (k == 6) ? 32'd1 : 32'd0);
    end
    tick();
    rd_chk("os_ctrl_en_cleared", TMR_CTRL_OFS, 32'h8);
    rd_chk("os_count_stays0", TMR_COUNT_OFS, 32'd0);
    chk("os_irq_sticky", 32'(irq), 32'd1);
    wr_reg(TMR_COUNT_OFS, 32'h55, 4'hF);
    rd_chk("count_ro", TMR_COUNT_OFS, 32'd0);
    wr_reg(TMR_STATUS_OFS, 32'h0, 4'hF);
    rd_chk("status_wr0_noeffect", TMR_STATUS_OFS, 32'd1);
    wr_reg(TMR_STATUS_OFS, 32'h1, 4'hE);
    rd_chk("status_clr_needs_be3", TMR_STATUS_OFS, 32'd1);
    wr_reg(TMR_STATUS_OFS, 32'h1, 4'h1);
    rd_chk("status_clr", TMR_STATUS_OFS, 32'd0);
    chk("irq_after_clr", 32'(irq), 32'd0);

    // Auto-reload, N=3: pending sets at E+4, E+9, E+14
    wr_reg(TMR_PRESET_OFS, 32'd3, 4'hF);
    wr_reg(TMR_CTRL_OFS, 32'hB, 4'hF);
    repeat (3) tick();
    rd_chk("ar_e3_status", TMR_STATUS_OFS, 32'd0);
    tick();
    rd_chk("ar_e4_status", TMR_STATUS_OFS, 32'd1);
    wr_reg(TMR_STATUS_OFS, 32'h1, 4'h1);
    rd_chk("ar_e5_cleared", TMR_STATUS_OFS, 32'd0);
    repeat (3) tick();
    rd_chk("ar_e8_count", TMR_COUNT_OFS, 32'd1);
    rd_chk("ar_e8_status", TMR_STATUS_OFS, 32'd0);
    tick();
    rd_chk("ar_e9_status", TMR_STATUS_OFS, 32'd1);
    wr_reg(TMR_STATUS_OFS, 32'h1, 4'h1);
    repeat (3) tick();
    rd_chk("ar_e13_status", TMR_STATUS_OFS, 32'd0);
    wr_reg(TMR_STATUS_OFS, 32'h1, 4'h1);
    rd_chk("ar_set_beats_clr", TMR_STATUS_OFS, 32'd1);
    chk("ar_irq", 32'(irq), 32'd1);
    wr_reg(TMR_CTRL_OFS, 32'h0, 4'hF);
    wr_reg(TMR_STATUS_OFS, 32'h1, 4'h1);
    rd_chk("ar_stop_status", TMR_STATUS_OFS, 32'd0);

    // Byte-enable merge
    wr_reg(TMR_PRESET_OFS, 32'h11223344, 4'hF);
    wr_reg(TMR_PRESET_OFS, 32'h000000AA, 4'b0001);
    rd_chk("be_lane3", TMR_PRESET_OFS, 32'h112233AA);
    wr_reg(TMR_PRESET_OFS, 32'hFF000000, 4'b1000);
    rd_chk("be_lane0", TMR_PRESET_OFS, 32'hFF2233AA);

    // Mid-count: EN rewrite does not restart; EN=0 holds COUNT
    wr_reg(TMR_PRESET_OFS, 32'd10, 4'hF);
    wr_reg(TMR_CTRL_OFS, 32'h1, 4'hF);
    tick();
    tick();
    rd_chk("mc_e2_count", TMR_COUNT_OFS, 32'd9);
    wr_reg(TMR_CTRL_OFS, 32'h1, 4'hF);
    rd_chk("mc_no_restart", TMR_COUNT_OFS, 32'd8);
    tick();
    rd_chk("mc_count7", TMR_COUNT_OFS, 32'd7);
    wr_reg(TMR_CTRL_OFS, 32'h0, 4'hF);
    rd_chk("mc_hold7", TMR_COUNT_OFS, 32'd7);
    tick();
    tick();
    rd_chk("mc_hold7_later", TMR_COUNT_OFS, 32'd7);

    // Auto-reload N=10, then async reset mid-count with irq high
    wr_reg(TMR_CTRL_OFS, 32'hB, 4'hF);
    repeat (15) tick();
    rd_chk("rs_count8", TMR_COUNT_OFS, 32'd8);
    chk("rs_irq_before", 32'(irq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_count_async", 32'(dout), 32'd0);
    chk("rs_irq_async", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    rd_chk("rs_idle_count", TMR_COUNT_OFS, 32'd0);
    rd_chk("rs_idle_ctrl", TMR_CTRL_OFS, 32'd0);

    // PRESET=0 acts as 1; software CTRL write wins over hardware EN clear
    wr_reg(TMR_PRESET_OFS, 32'd0, 4'hF);
    wr_reg(TMR_CTRL_OFS, 32'h1, 4'hF);
    tick();
    rd_chk("p0_count1", TMR_COUNT_OFS, 32'd1);
    tick();
    rd_chk("p0_pending", TMR_STATUS_OFS, 32'd1);
    chk("p0_irq_masked", 32'(irq), 32'd0);
    wr_reg(TMR_CTRL_OFS, 32'h9, 4'hF);
    rd_chk("p0_sw_wins", TMR_CTRL_OFS, 32'h9);
    chk("p0_irq_unmasked", 32'(irq), 32'd1);
    wr_reg(TMR_CTRL_OFS, 32'h0, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
